// File: rtl/dm_arbiter.sv
// dm_arbiter: two cores share a dual-port RAM, p0 on port A and p1 on port B.
// Same-address accesses involving a write are serialised by a rotating priority bit.
module dm_arbiter #(
    parameter int AW  = 9,
    parameter int MAW = 8,
    parameter int DW  = 16
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           p0_req,
    input  logic           p0_we,
    input  logic [AW-1:0]  p0_addr,
    input  logic [DW-1:0]  p0_wdata,
    output logic           p0_gnt,
    output logic           p0_rvalid,
    output logic [DW-1:0]  p0_rdata,
    output logic           p0_err,

    input  logic           p1_req,
    input  logic           p1_we,
    input  logic [AW-1:0]  p1_addr,
    input  logic [DW-1:0]  p1_wdata,
    output logic           p1_gnt,
    output logic           p1_rvalid,
    output logic [DW-1:0]  p1_rdata,
    output logic           p1_err,

    output logic [MAW-1:0] mem_addr_a,
    output logic [DW-1:0]  mem_data_a,
    output logic           mem_we_a,
    input  logic [DW-1:0]  mem_q_a,

    output logic [MAW-1:0] mem_addr_b,
    output logic [DW-1:0]  mem_data_b,
    output logic           mem_we_b,
    input  logic [DW-1:0]  mem_q_b,

    output logic [15:0]    conflict_cnt
);

    logic        p0Oor;
    logic        p1Oor;
    logic        conflict;

    logic        prio_q;
    logic        prio_d;
    logic [15:0] conflictCnt_q;
    logic [15:0] conflictCnt_d;

    logic        p0Rvalid_q;
    logic        p0Rvalid_d;
    logic        p0InRange_q;
    logic        p0InRange_d;
    logic        p0Err_q;
    logic        p0Err_d;

    logic        p1Rvalid_q;
    logic        p1Rvalid_d;
    logic        p1InRange_q;
    logic        p1InRange_d;
    logic        p1Err_q;
    logic        p1Err_d;

    // Any set bit above the RAM address width means the word does not exist.
    generate
        if (AW > MAW) begin : g_upper
            assign p0Oor = |p0_addr[AW-1:MAW];
            assign p1Oor = |p1_addr[AW-1:MAW];
        end else begin : g_noUpper
            assign p0Oor = 1'b0;
            assign p1Oor = 1'b0;
        end
    endgenerate

    assign mem_addr_a = p0_addr[MAW-1:0];
    assign mem_addr_b = p1_addr[MAW-1:0];
    assign mem_data_a = p0_wdata;
    assign mem_data_b = p1_wdata;

    // Only the low RAM bits are compared, so aliasing out-of-range addresses also collide.
    assign conflict = rst & p0_req & p1_req
                    & (p0_addr[MAW-1:0] == p1_addr[MAW-1:0])
                    & (p0_we | p1_we);

    assign p0_gnt = rst & p0_req & (~conflict | ~prio_q);
    assign p1_gnt = rst & p1_req & (~conflict |  prio_q);

    assign mem_we_a = p0_gnt & p0_we & ~p0Oor;
    assign mem_we_b = p1_gnt & p1_we & ~p1Oor;

    always_comb begin
        prio_d        = prio_q ^ conflict;
        conflictCnt_d = conflictCnt_q;
        if (conflict && (conflictCnt_q != 16'hFFFF)) begin
            conflictCnt_d = conflictCnt_q + 16'd1;
        end

        p0Rvalid_d  = p0_gnt & ~p0_we;
        p0InRange_d = ~p0Oor;
        p0Err_d     = p0_gnt & p0Oor;

        p1Rvalid_d  = p1_gnt & ~p1_we;
        p1InRange_d = ~p1Oor;
        p1Err_d     = p1_gnt & p1Oor;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q        <= 1'b0;
            conflictCnt_q <= 16'd0;
            p0Rvalid_q    <= 1'b0;
            p0InRange_q   <= 1'b0;
            p0Err_q       <= 1'b0;
            p1Rvalid_q    <= 1'b0;
            p1InRange_q   <= 1'b0;
            p1Err_q       <= 1'b0;
        end else begin
            prio_q        <= prio_d;
            conflictCnt_q <= conflictCnt_d;
            p0Rvalid_q    <= p0Rvalid_d;
            p0InRange_q   <= p0InRange_d;
            p0Err_q       <= p0Err_d;
            p1Rvalid_q    <= p1Rvalid_d;
            p1InRange_q   <= p1InRange_d;
            p1Err_q       <= p1Err_d;
        end
    end

    // Out-of-range reads still return a valid beat, but with the RAM data masked off.
    assign p0_rvalid = p0Rvalid_q;
    assign p0_rdata  = (p0Rvalid_q & p0InRange_q) ? mem_q_a : '0;
    assign p0_err    = p0Err_q;

    assign p1_rvalid = p1Rvalid_q;
    assign p1_rdata  = (p1Rvalid_q & p1InRange_q) ? mem_q_b : '0;
    assign p1_err    = p1Err_q;

    assign conflict_cnt = conflictCnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed vectors for dm_arbiter with a queue-based response scoreboard
// and a behavioural dual-port RAM with one-cycle read latency.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [8:0]  p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic [7:0]  mem_addr_a, mem_addr_b;
    logic [15:0] mem_data_a, mem_data_b, mem_q_a, mem_q_b;
    logic        mem_we_a, mem_we_b;
    logic [15:0] conflict_cnt;

    logic [15:0] ram [0:255];

    typedef struct {
        int          due;
        logic        rv;
        logic        er;
        logic [15:0] data;
    } rsp_t;

    rsp_t exp0[$];
    rsp_t exp1[$];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic monitorOn = 1'b0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(9), .MAW(8), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .mem_we_a(mem_we_a), .mem_q_a(mem_q_a),
        .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_we_b(mem_we_b), .mem_q_b(mem_q_b),
        .conflict_cnt(conflict_cnt)
    );

    always @(posedge clk) begin
        if (mem_we_a) ram[mem_addr_a] <= mem_data_a;
        if (mem_we_b) ram[mem_addr_b] <= mem_data_b;
        mem_q_a <= ram[mem_addr_a];
        mem_q_b <= ram[mem_addr_b];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // c0/c1 = {req, we}; eg = {p0_gnt, p1_gnt, mem_we_a, mem_we_b}; r0/r1 = {rvalid, err} due next cycle
    task automatic applyStimulus(input string name, input logic rstN,
                                 input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] d0,
                                 input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] d1,
                                 input logic [3:0] eg,
                                 input logic [1:0] r0, input logic [15:0] q0,
                                 input logic [1:0] r1, input logic [15:0] q1);
        @(posedge clk);
        #1;
        rst      = rstN;
        p0_req   = c0[1];
        p0_we    = c0[0];
        p0_addr  = a0;
        p0_wdata = d0;
        p1_req   = c1[1];
        p1_we    = c1[0];
        p1_addr  = a1;
        p1_wdata = d1;
        if (r0 != 2'b00) exp0.push_back('{cyc + 1, r0[1], r0[0], q0});
        if (r1 != 2'b00) exp1.push_back('{cyc + 1, r1[1], r1[0], q1});
        #1;
        checkOutput({name, " p0_gnt"},     16'(p0_gnt),     16'(eg[3]));
        checkOutput({name, " p1_gnt"},     16'(p1_gnt),     16'(eg[2]));
        checkOutput({name, " mem_we_a"},   16'(mem_we_a),   16'(eg[1]));
        checkOutput({name, " mem_we_b"},   16'(mem_we_b),   16'(eg[0]));
        checkOutput({name, " mem_addr_a"}, 16'(mem_addr_a), 16'(a0[7:0]));
        checkOutput({name, " mem_addr_b"}, 16'(mem_addr_b), 16'(a1[7:0]));
        checkOutput({name, " mem_data_a"}, mem_data_a,      d0);
        checkOutput({name, " mem_data_b"}, mem_data_b,      d1);
    endtask

    // Responses are compared when due; any other cycle must be quiet with zero read data.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (exp0.size() > 0 && exp0[0].due == cyc) begin
                checkOutput("p0_rvalid", 16'(p0_rvalid), 16'(exp0[0].rv));
                checkOutput("p0_err",    16'(p0_err),    16'(exp0[0].er));
                checkOutput("p0_rdata",  p0_rdata,       exp0[0].data);
                void'(exp0.pop_front());
            end else begin
                checkOutput("p0 idle rvalid/err", {14'd0, p0_rvalid, p0_err}, 16'h0000);
                checkOutput("p0 idle rdata", p0_rdata, 16'h0000);
            end
            if (exp1.size() > 0 && exp1[0].due == cyc) begin
                checkOutput("p1_rvalid", 16'(p1_rvalid), 16'(exp1[0].rv));
                checkOutput("p1_err",    16'(p1_err),    16'(exp1[0].er));
                checkOutput("p1_rdata",  p1_rdata,       exp1[0].data);
                void'(exp1.pop_front());
            end else begin
                checkOutput("p1 idle rvalid/err", {14'd0, p1_rvalid, p1_err}, 16'h0000);
                checkOutput("p1 idle rdata", p1_rdata, 16'h0000);
            end
        end
    end

    initial begin
        rst = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h00] = 16'h0F0F;
        ram[8'h34] = 16'h3434;

        applyStimulus("reset0", 1'b0, 2'b11, 9'h012, 16'hBEEF, 2'b10, 9'h034, 16'h0000, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        applyStimulus("reset1", 1'b0, 2'b11, 9'h012, 16'hBEEF, 2'b10, 9'h034, 16'h0000, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        monitorOn = 1'b1;
        checkOutput("reset conflict_cnt", conflict_cnt, 16'h0000);

        applyStimulus("wr12_rd34", 1'b1, 2'b11, 9'h012, 16'hBEEF, 2'b10, 9'h034, 16'h0000, 4'b1110, 2'b00, 16'h0, 2'b10, 16'h3434);
        applyStimulus("rd12_rd12", 1'b1, 2'b10, 9'h012, 16'h0000, 2'b10, 9'h012, 16'h0000, 4'b1100, 2'b10, 16'hBEEF, 2'b10, 16'hBEEF);
        applyStimulus("rd34_b2b",  1'b1, 2'b00, 9'h000, 16'h0000, 2'b10, 9'h034, 16'h0000, 4'b0100, 2'b00, 16'h0, 2'b10, 16'h3434);
        checkOutput("cnt no conflicts", conflict_cnt, 16'h0000);

        applyStimulus("ww_c0", 1'b1, 2'b11, 9'h005, 16'h1111, 2'b11, 9'h005, 16'h2222, 4'b1010, 2'b00, 16'h0, 2'b00, 16'h0);
        applyStimulus("ww_c1", 1'b1, 2'b00, 9'h000, 16'h0000, 2'b11, 9'h005, 16'h2222, 4'b0101, 2'b00, 16'h0, 2'b00, 16'h0);
        applyStimulus("rd05",  1'b1, 2'b10, 9'h005, 16'h0000, 2'b00, 9'h000, 16'h0000, 4'b1000, 2'b10, 16'h2222, 2'b00, 16'h0);
        checkOutput("cnt after ww", conflict_cnt, 16'h0001);

        applyStimulus("rw_c0", 1'b1, 2'b10, 9'h007, 16'h0000, 2'b11, 9'h007, 16'hA5A5, 4'b0101, 2'b00, 16'h0, 2'b00, 16'h0);
        applyStimulus("rw_c1", 1'b1, 2'b10, 9'h007, 16'h0000, 2'b00, 9'h007, 16'h0000, 4'b1000, 2'b10, 16'hA5A5, 2'b00, 16'h0);
        checkOutput("cnt after rw", conflict_cnt, 16'h0002);

        applyStimulus("oor_wr", 1'b1, 2'b11, 9'h100, 16'hFFFF, 2'b00, 9'h000, 16'h0000, 4'b1000, 2'b01, 16'h0000, 2'b00, 16'h0);
        applyStimulus("oor_rd", 1'b1, 2'b10, 9'h100, 16'h0000, 2'b00, 9'h000, 16'h0000, 4'b1000, 2'b11, 16'h0000, 2'b00, 16'h0);
        applyStimulus("rd000",  1'b1, 2'b00, 9'h000, 16'h0000, 2'b10, 9'h000, 16'h0000, 4'b0100, 2'b00, 16'h0, 2'b10, 16'h0F0F);

        applyStimulus("ww20_c0", 1'b1, 2'b11, 9'h020, 16'hAAAA, 2'b11, 9'h020, 16'hBBBB, 4'b1010, 2'b00, 16'h0, 2'b00, 16'h0);
        applyStimulus("ww20_c1", 1'b1, 2'b00, 9'h000, 16'h0000, 2'b11, 9'h020, 16'hBBBB, 4'b0101, 2'b00, 16'h0, 2'b00, 16'h0);
        checkOutput("cnt before reset", conflict_cnt, 16'h0003);

        applyStimulus("rd34_pre_rst", 1'b1, 2'b00, 9'h000, 16'h0000, 2'b10, 9'h034, 16'h0000, 4'b0100, 2'b00, 16'h0, 2'b00, 16'h0);
        rst = 1'b0;
        #1;
        checkOutput("gnt forced low in reset", 16'(p1_gnt), 16'h0000);
        applyStimulus("rst_hold", 1'b0, 2'b11, 9'h030, 16'h1234, 2'b11, 9'h030, 16'h5678, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        applyStimulus("rst_rel",  1'b1, 2'b00, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        checkOutput("cnt after reset", conflict_cnt, 16'h0000);
        applyStimulus("prio_after_rst", 1'b1, 2'b11, 9'h021, 16'h0001, 2'b11, 9'h021, 16'h0002, 4'b1010, 2'b00, 16'h0, 2'b00, 16'h0);

        applyStimulus("rst_sat",   1'b0, 2'b00, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        applyStimulus("sat_start", 1'b1, 2'b00, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h040; p0_wdata = 16'h0001;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h040; p1_wdata = 16'h0002;
        repeat (65533) @(posedge clk);
        applyStimulus("sat_idle0", 1'b1, 2'b00, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        checkOutput("cnt at FFFE", conflict_cnt, 16'hFFFE);
        applyStimulus("sat_one",   1'b1, 2'b11, 9'h040, 16'h0001, 2'b11, 9'h040, 16'h0002, 4'b1010, 2'b00, 16'h0, 2'b00, 16'h0);
        applyStimulus("sat_idle1", 1'b1, 2'b00, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        checkOutput("cnt at FFFF", conflict_cnt, 16'hFFFF);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h040;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h040;
        repeat (2) @(posedge clk);
        applyStimulus("sat_idle2", 1'b1, 2'b00, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000, 4'b0000, 2'b00, 16'h0, 2'b00, 16'h0);
        checkOutput("cnt saturated", conflict_cnt, 16'hFFFF);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("pending responses", 16'(exp0.size() + exp1.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
